// File: rtl/seq_counter_pkg.sv
// Shared types and helpers for the sequenced counter / digit-scan controller.
package seq_counter_pkg;

    typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} dir_t;

    // Digit index needs at least one bit even for tiny displays.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seq_counter_ctrl_tick_gen.sv
// Prescaler: counts enabled cycles and flags the cycle in which pre has reached div.
module tick_gen #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] div,
    output logic         tick_pre
);

    logic [W-1:0] r_pre;

    // Combinational strobe so the consumer registers its step in the same edge that clears pre.
    assign tick_pre = en && (r_pre >= div);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre <= '0;
        end else if (clr) begin
            r_pre <= '0;
        end else if (en) begin
            r_pre <= tick_pre ? '0 : r_pre + 1'b1;
        end
    end

endmodule

// File: rtl/seq_counter_ctrl.sv
// Programmable up/down modulo counter with load, tick/tc pulses, and a free-running digit scan.
module seq_counter_ctrl
    import seq_counter_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int DIV_W    = 24,
    parameter int DIGITS   = 8,
    parameter int SCAN_DIV = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           en,
    input  logic                           up,
    input  logic                           load,
    input  logic [WIDTH-1:0]               load_val,
    input  logic [DIV_W-1:0]               div,
    input  logic [WIDTH-1:0]               limit,
    output logic [WIDTH-1:0]               cntr,
    output logic                           tick,
    output logic                           tc,
    output logic                           wrapped,
    output logic [clog2_min1(DIGITS)-1:0]  digit
);

    localparam int DW = clog2_min1(DIGITS);

    logic             w_step;
    logic             w_scan_strobe;
    dir_t             w_dir;
    logic [WIDTH-1:0] r_cntr;
    logic             r_tick;
    logic             r_tc;
    logic             r_wrapped;
    logic [DW-1:0]    r_digit;

    assign w_dir = dir_t'(up);

    tick_gen #(.W(DIV_W)) u_count_pre (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .clr      (load),
        .div      (div),
        .tick_pre (w_step)
    );

    tick_gen #(.W(SCAN_DIV)) u_scan_pre (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (1'b1),
        .clr      (1'b0),
        .div      ({SCAN_DIV{1'b1}}),
        .tick_pre (w_scan_strobe)
    );

    // Load outranks any step that the prescaler offers in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cntr    <= '0;
            r_tick    <= 1'b0;
            r_tc      <= 1'b0;
            r_wrapped <= 1'b0;
        end else if (load) begin
            r_cntr    <= load_val;
            r_tick    <= 1'b0;
            r_tc      <= 1'b0;
            r_wrapped <= 1'b0;
        end else begin
            r_tick <= w_step;
            r_tc   <= 1'b0;
            if (w_step) begin
                if (w_dir == DIR_UP) begin
                    if (r_cntr >= limit) begin
                        r_cntr    <= '0;
                        r_tc      <= 1'b1;
                        r_wrapped <= 1'b1;
                    end else begin
                        r_cntr <= r_cntr + 1'b1;
                    end
                end else begin
                    if (r_cntr == '0) begin
                        r_cntr    <= limit;
                        r_tc      <= 1'b1;
                        r_wrapped <= 1'b1;
                    end else begin
                        r_cntr <= r_cntr - 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digit <= '0;
        end else if (w_scan_strobe) begin
            r_digit <= (r_digit == DW'(DIGITS - 1)) ? '0 : r_digit + 1'b1;
        end
    end

    assign cntr    = r_cntr;
    assign tick    = r_tick;
    assign tc      = r_tc;
    assign wrapped = r_wrapped;
    assign digit   = r_digit;

endmodule
